// File: rtl/ahb_gcd_pkg.sv
// Shared constants for the AHB-Lite GCD front end: register offsets, bit
// positions and the launch/wait FSM encoding.
package ahb_gcd_pkg;

  localparam logic [31:0] ID_VALUE = 32'h0000_6CD0;

  localparam logic [2:0] OFS_OPA    = 3'd0;
  localparam logic [2:0] OFS_OPB    = 3'd1;
  localparam logic [2:0] OFS_CTRL   = 3'd2;
  localparam logic [2:0] OFS_STAT   = 3'd3;
  localparam logic [2:0] OFS_RESULT = 3'd4;
  localparam logic [2:0] OFS_ID     = 3'd5;

  localparam int CTRL_START = 0;
  localparam int CTRL_IE    = 1;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVR  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } gcd_state_t;

endpackage

// File: rtl/ahb_gcd_if_gcd_ctrl_fsm.sv
// Launch/wait sequencer for the GCD core: issues the start pulse, masks the
// core's stale done level, and owns the RESULT register.
module gcd_ctrl_fsm
  import ahb_gcd_pkg::*;
(
  input  logic        clk,
  input  logic        RST,
  input  logic        start_wr,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        gcd_done,
  input  logic [31:0] gcd_result,
  output logic        gcd_start,
  output logic        busy,
  output logic        start_accept,
  output logic        done_set,
  output logic [31:0] result,
  output gcd_state_t  state
);

  gcd_state_t  state_nxt;
  logic        capture;
  logic [31:0] capture_val;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (capture) result <= capture_val;
    end
  end

  // gcd_done is only looked at in WAIT; during LAUNCH it still reflects the
  // previous operation.
  always_comb begin
    state_nxt    = state;
    gcd_start    = 1'b0;
    start_accept = 1'b0;
    done_set     = 1'b0;
    capture      = 1'b0;
    capture_val  = gcd_result;
    case (state)
      IDLE: begin
        if (start_wr) begin
          start_accept = 1'b1;
          if (opa == 32'd0) begin
            capture     = 1'b1;
            capture_val = opb;
            done_set    = 1'b1;
          end else begin
            state_nxt = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        gcd_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (gcd_done) begin
          capture   = 1'b1;
          done_set  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/ahb_gcd_if.sv
// AHB-Lite register front end for the GCD core: address decode, OPA/OPB/CTRL/
// STAT registers, read mux and completion interrupt.
module ahb_gcd_if
  import ahb_gcd_pkg::*;
(
  input  logic        clk,
  input  logic        RST,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        gcd_start,
  output logic [31:0] gcd_a,
  output logic [31:0] gcd_b,
  input  logic [31:0] gcd_result,
  input  logic        gcd_done,
  output logic        irq
);

  logic        dp_valid;
  logic        dp_write;
  logic [2:0]  dp_addr;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        ie;
  logic        done;
  logic        ovr;
  logic [31:0] result;
  logic        busy;
  logic        start_accept;
  logic        done_set;
  gcd_state_t  fsm_state;
  logic        unused_ok;

  // A transfer is accepted (valid) when HSEL & HTRANS[1] while HREADY (ready)
  // is high; its data phase is the following cycle and writes commit at the
  // edge that ends it. This slave never stretches a data phase.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
    end else if (HREADY) begin
      dp_valid <= HSEL & HTRANS[1];
      dp_write <= HWRITE;
      dp_addr  <= HADDR[4:2];
    end
  end

  logic wr_en, rd_en, wr_opa, wr_opb, wr_ctrl, wr_stat, start_wr;

  assign wr_en    = dp_valid & dp_write;
  assign rd_en    = dp_valid & ~dp_write;
  assign wr_opa   = wr_en & (dp_addr == OFS_OPA);
  assign wr_opb   = wr_en & (dp_addr == OFS_OPB);
  assign wr_ctrl  = wr_en & (dp_addr == OFS_CTRL);
  assign wr_stat  = wr_en & (dp_addr == OFS_STAT);
  assign start_wr = wr_ctrl & HWDATA[CTRL_START];

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      opa  <= '0;
      opb  <= '0;
      ie   <= 1'b0;
      done <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      if (wr_opa && !busy) opa <= HWDATA;
      if (wr_opb && !busy) opb <= HWDATA;
      if (wr_ctrl) ie <= HWDATA[CTRL_IE];
      if (busy && (wr_opa || wr_opb || start_wr)) ovr <= 1'b1;
      else if (wr_stat && HWDATA[STAT_OVR]) ovr <= 1'b0;
      // A completion in the same cycle as a DONE W1C keeps DONE set.
      if (done_set) done <= 1'b1;
      else if (start_accept || (wr_stat && HWDATA[STAT_DONE])) done <= 1'b0;
    end
  end

  gcd_ctrl_fsm u_fsm (
    .clk          (clk),
    .RST          (RST),
    .start_wr     (start_wr),
    .opa          (opa),
    .opb          (opb),
    .gcd_done     (gcd_done),
    .gcd_result   (gcd_result),
    .gcd_start    (gcd_start),
    .busy         (busy),
    .start_accept (start_accept),
    .done_set     (done_set),
    .result       (result),
    .state        (fsm_state)
  );

  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      case (dp_addr)
        OFS_OPA:    HRDATA = opa;
        OFS_OPB:    HRDATA = opb;
        OFS_CTRL:   HRDATA[CTRL_IE] = ie;
        OFS_STAT: begin
          HRDATA[STAT_BUSY] = busy;
          HRDATA[STAT_DONE] = done;
          HRDATA[STAT_OVR]  = ovr;
        end
        OFS_RESULT: HRDATA = result;
        OFS_ID:     HRDATA = ID_VALUE;
        default:    HRDATA = '0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign gcd_a     = opa;
  assign gcd_b     = opb;
  assign irq       = done & ie;

  assign unused_ok = &{1'b0, HSIZE, HADDR[31:5], HADDR[1:0], HTRANS[0], fsm_state};

endmodule
